// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UartTx byte transmitter among NUM_REQ producers.
// Define UART_ARB_LOCK_EN to let a requester keep its grant across a multi-byte packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int IDX_W        = 2,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           tx_data,
  output logic                 tx_latch,
  input  logic                 tx_busy,
  output logic                 active,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 timeout_err
);

  localparam int TCNT_W = $clog2(BUSY_TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    win_idx;
  logic                win_found;
  logic [7:0]          win_data;
  logic [IDX_W-1:0]    ptr_after;
  logic [TCNT_W-1:0]   tcnt;
  logic                grant;
  logic                keep_ptr;

  // Scan requesters starting at rr_ptr; the first pending one wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == win_idx) win_data = req_data[8*k +: 8];
    end
  end

  assign grant     = (state == IDLE) && win_found && !tx_busy;
  assign ptr_after = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

`ifdef UART_ARB_LOCK_EN
  logic lock_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        lock_q <= 1'b0;
    else if (grant) lock_q <= req_lock[win_idx];
  end

  assign keep_ptr = lock_q;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign keep_ptr    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant) state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)                state_nxt = WAIT_DONE;
        else if (tcnt == TCNT_LAST) state_nxt = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Registered outputs; a timed-out byte is dropped and the pointer always advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack         <= '0;
      tx_data     <= '0;
      tx_latch    <= 1'b0;
      active      <= 1'b0;
      grant_idx   <= '0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      tcnt        <= '0;
    end else begin
      ack         <= '0;
      tx_latch    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            tx_data   <= win_data;
            tx_latch  <= 1'b1;
            ack       <= NUM_REQ'(1) << win_idx;
            grant_idx <= win_idx;
            active    <= 1'b1;
            tcnt      <= '0;
          end
        end
        WAIT_BUSY: begin
          if (!tx_busy) begin
            if (tcnt == TCNT_LAST) begin
              timeout_err <= 1'b1;
              active      <= 1'b0;
              rr_ptr      <= ptr_after;
            end else begin
              tcnt <= tcnt + TCNT_W'(1);
            end
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            active <= 1'b0;
            rr_ptr <= keep_ptr ? grant_idx : ptr_after;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter against a transaction-level model.
// Lock expectations follow UART_ARB_LOCK_EN when the bench is built with it.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int BT = 4;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [31:0]  req_data;
  logic [3:0]   req_lock;
  logic [3:0]   ack;
  logic [7:0]   tx_data;
  logic         tx_latch;
  logic         tx_busy;
  logic         active;
  logic [1:0]   grant_idx;
  logic         timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int rr_model     = 0;
  int last_grant   = 0;
  int ack_count [N];

  uart_tx_arbiter #(.NUM_REQ(N), .IDX_W(2), .BUSY_TIMEOUT(BT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_lock   (req_lock),
    .ack        (ack),
    .tx_data    (tx_data),
    .tx_latch   (tx_latch),
    .tx_busy    (tx_busy),
    .active     (active),
    .grant_idx  (grant_idx),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requests seen outside IDLE must be ignored, so hammer the inputs then.
  task automatic scramble();
    req      = 4'($urandom);
    req_data = $urandom;
    req_lock = 4'($urandom);
  endtask

  function automatic int pickWinner(input logic [3:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic idleCycles(input int n);
    req = 4'b0000;
    for (int c = 0; c < n; c++) begin
      tick();
      checkOutput("idle no latch", tx_latch, 0);
      checkOutput("idle inactive", active, 0);
    end
  endtask

  task automatic busyIdle(input logic [3:0] r, input int n);
    req     = r;
    tx_busy = 1'b1;
    for (int c = 0; c < n; c++) begin
      tick();
      checkOutput("busy no latch", tx_latch, 0);
      checkOutput("busy no ack", ack, 0);
    end
  endtask

  // One byte: grant, then UartTx raises busy after `delay` cycles (negative = never).
  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input logic [3:0] lk,
                               input int delay, input int len);
    int   w;
    logic locked;
    req      = r;
    req_data = d;
    req_lock = lk;
    tx_busy  = 1'b0;
    w = pickWinner(r, rr_model);
    tick();
    checkOutput("latch", tx_latch, 1);
    checkOutput("ack", ack, 32'(1) << w);
    checkOutput("tx_data", tx_data, d[8*w +: 8]);
    checkOutput("grant_idx", grant_idx, w);
    checkOutput("active", active, 1);
    last_grant = grant_idx;
    for (int i = 0; i < N; i++) if (ack[i]) ack_count[i]++;
`ifdef UART_ARB_LOCK_EN
    locked = lk[w];
`else
    locked = 1'b0;
`endif
    if (delay < 0) begin
      for (int c = 1; c <= BT; c++) begin
        scramble();
        tick();
        checkOutput("to no latch", tx_latch, 0);
        if (c < BT) begin
          checkOutput("to early", timeout_err, 0);
          checkOutput("to active", active, 1);
        end else begin
          checkOutput("timeout_err", timeout_err, 1);
          checkOutput("to idle", active, 0);
        end
      end
      rr_model = (w + 1) % N;
    end else begin
      for (int c = 0; c < delay; c++) begin
        scramble();
        tick();
        checkOutput("wb no latch", tx_latch, 0);
        checkOutput("wb no ack", ack, 0);
        checkOutput("wb no timeout", timeout_err, 0);
        checkOutput("wb active", active, 1);
      end
      tx_busy = 1'b1;
      for (int c = 0; c < len; c++) begin
        scramble();
        tick();
        checkOutput("wd no latch", tx_latch, 0);
        checkOutput("wd no timeout", timeout_err, 0);
        checkOutput("wd active", active, 1);
      end
      tx_busy = 1'b0;
      scramble();
      tick();
      checkOutput("done idle", active, 0);
      checkOutput("done no latch", tx_latch, 0);
      rr_model = locked ? w : (w + 1) % N;
    end
  endtask

  initial begin
    int exp_lock [4];
    logic [3:0] r;
    int dly;

    rst      = 1'b1;
    req      = 4'b1111;
    req_data = 32'h0;
    req_lock = 4'b0;
    tx_busy  = 1'b1;
    for (int i = 0; i < N; i++) ack_count[i] = 0;

    repeat (3) tick();
    checkOutput("rst ack", ack, 0);
    checkOutput("rst tx_data", tx_data, 0);
    checkOutput("rst tx_latch", tx_latch, 0);
    checkOutput("rst active", active, 0);
    checkOutput("rst grant_idx", grant_idx, 0);
    checkOutput("rst timeout_err", timeout_err, 0);
    rst = 1'b0;
    rr_model = 0;
    busyIdle(4'b1111, 3);
    applyStimulus(4'b1111, 32'h44332211, 4'b0, 0, 2);
    checkOutput("first after reset", last_grant, 0);

    applyStimulus(4'b0100, 32'h00A50000, 4'b0, 0, 3);
    checkOutput("single grant", last_grant, 2);

    for (int i = 0; i < N; i++) ack_count[i] = 0;
    for (int t = 0; t < 8; t++)
      applyStimulus(4'b1111, $urandom, 4'b0, int'($urandom_range(0, BT-1)), int'($urandom_range(1, 4)));
    for (int i = 0; i < N; i++) checkOutput("fair count", ack_count[i], 2);

    applyStimulus(4'b0100, $urandom, 4'b0, 1, 1);
    applyStimulus(4'b1001, $urandom, 4'b0, 0, 2);
    checkOutput("wrap first", last_grant, 3);
    applyStimulus(4'b1001, $urandom, 4'b0, 0, 2);
    checkOutput("wrap second", last_grant, 0);

    applyStimulus(4'b0110, $urandom, 4'b0, -1, 0);
    checkOutput("timeout grant", last_grant, 1);
    applyStimulus(4'b0110, $urandom, 4'b0, 0, 1);
    checkOutput("after timeout", last_grant, 2);

    applyStimulus(4'b1000, $urandom, 4'b0, 0, 1);
`ifdef UART_ARB_LOCK_EN
    exp_lock = '{0, 0, 0, 1};
`else
    exp_lock = '{0, 1, 0, 1};
`endif
    for (int t = 0; t < 4; t++) begin
      applyStimulus(4'b0011, $urandom, (t < 2) ? 4'b0001 : 4'b0000, 0, 2);
      checkOutput("lock order", last_grant, exp_lock[t]);
    end

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 2)));
      r = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) busyIdle(r, int'($urandom_range(1, 2)));
      dly = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, BT-1));
      applyStimulus(r, $urandom, 4'($urandom), dly, int'($urandom_range(1, 4)));
    end

    req      = 4'b0100;
    req_data = 32'h00770000;
    tx_busy  = 1'b0;
    tick();
    tx_busy = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst active", active, 0);
    checkOutput("async rst grant_idx", grant_idx, 0);
    checkOutput("async rst tx_data", tx_data, 0);
    tick();
    rst = 1'b0;
    rr_model = 0;
    busyIdle(4'b1111, 3);
    applyStimulus(4'b0110, $urandom, 4'b0, 0, 1);
    checkOutput("ptr after rst", last_grant, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
